// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon share loader.
package ascon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } state_t;

   localparam int NONCE_W = 128;
   localparam int SHARES  = 3;
   localparam int LFSR_W  = 32;
   // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

   // Three Boolean shares: two fresh masks on top, masked bit at [0].
   function automatic logic [SHARES-1:0] share_enc(input logic b, input logic [1:0] m);
      return {m, b ^ m[1] ^ m[0]};
   endfunction

endpackage

// File: rtl/ascon_share_loader_if.sv
// Job handshake bundle. Transfer occurs on a posedge with load_valid && load_ready.
interface ascon_share_loader_if #(
   parameter int K = 128,
   parameter int L = 40,
   parameter int Y = 40
);
   logic         load_valid;
   logic         load_ready;
   logic [K-1:0] key_in;
   logic [127:0] nonce_in;
   logic [L-1:0] ad_in;
   logic [Y-1:0] pt_in;

   modport master (output load_valid, key_in, nonce_in, ad_in, pt_in, input load_ready);
   modport slave  (input load_valid, key_in, nonce_in, ad_in, pt_in, output load_ready);
endinterface

// File: rtl/ascon_lfsr.sv
// 32-bit Galois LFSR producing OUT_W fresh bits per clock via an unrolled update.
module ascon_lfsr
   import ascon_pkg::*;
#(
   parameter int                OUT_W = 15,
   parameter logic [LFSR_W-1:0] SEED  = 32'hACE1_5EED
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] rnd_o
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      rnd_o  = '0;
      for (int s = 0; s < OUT_W; s++) begin
         rnd_o[s] = lfsr_d[0];
         lfsr_d   = lfsr_d[0] ? ((lfsr_d >> 1) ^ LFSR_TAPS) : (lfsr_d >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/ascon_share_loader.sv
// Splits a parallel Ascon job into 3 Boolean shares and streams it MSB-first to the serial core.
// ASCON_LOADER_LFSR_EN selects the internal PRNG instead of the rand_in port.
module ascon_share_loader
   import ascon_pkg::*;
#(
   parameter int          k            = 128,
   parameter int          l            = 40,
   parameter int          y            = 40,
   parameter int          RW           = 7,
   parameter int          START_CYCLES = 3,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_5EED
) (
   input  logic                 clk,
   input  logic                 rst,
   ascon_share_loader_if.slave  ld,
   input  logic                 enc_ready_in,
`ifndef ASCON_LOADER_LFSR_EN
   input  logic [RW+7:0]        rand_in,
`endif
   output logic [SHARES-1:0]    keyxSI,
   output logic [SHARES-1:0]    noncexSI,
   output logic [SHARES-1:0]    associated_dataxSI,
   output logic [SHARES-1:0]    plain_textxSI,
   output logic [RW-1:0]        rxSI,
   output logic                 encryption_startxSI,
   output logic                 busy,
   output state_t               dbg_state_o
);

   localparam int CW = $clog2(k + 1);
   localparam int SW = $clog2(START_CYCLES + 1);

   logic [RW+7:0] rnd;

`ifdef ASCON_LOADER_LFSR_EN
   ascon_lfsr #(.OUT_W(RW + 8), .SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .rnd_o (rnd)
   );
`else
   assign rnd = rand_in;
`endif

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [SW-1:0]       scnt_q;
   logic [k-1:0]        key_q, ad_q, pt_q;
   logic [NONCE_W-1:0]  nonce_q;
   logic [SHARES-1:0]   key_sh_q, nonce_sh_q, ad_sh_q, pt_sh_q;
   logic [RW-1:0]       rx_q;
   logic                start_q, busy_q, ready_q;
   logic [k-1:0]        ad_ext, pt_ext;

   // Left-align AD/PT so the shift-out is uniform; bits past their length read as 0.
   always_comb begin
      ad_ext         = '0;
      pt_ext         = '0;
      ad_ext[l-1:0]  = ld.ad_in;
      pt_ext[y-1:0]  = ld.pt_in;
      ad_ext         = ad_ext << (k - l);
      pt_ext         = pt_ext << (k - y);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         scnt_q     <= '0;
         key_q      <= '0;
         nonce_q    <= '0;
         ad_q       <= '0;
         pt_q       <= '0;
         key_sh_q   <= '0;
         nonce_sh_q <= '0;
         ad_sh_q    <= '0;
         pt_sh_q    <= '0;
         rx_q       <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         rx_q <= rnd[RW+7:8];
         case (state_q)
            IDLE: begin
               if (ld.load_valid) begin
                  state_q    <= SHIFT;
                  busy_q     <= 1'b1;
                  ready_q    <= 1'b0;
                  cnt_q      <= '0;
                  key_q      <= {ld.key_in[k-2:0], 1'b0};
                  nonce_q    <= {ld.nonce_in[NONCE_W-2:0], 1'b0};
                  ad_q       <= {ad_ext[k-2:0], 1'b0};
                  pt_q       <= {pt_ext[k-2:0], 1'b0};
                  key_sh_q   <= share_enc(ld.key_in[k-1], rnd[1:0]);
                  nonce_sh_q <= share_enc(ld.nonce_in[NONCE_W-1], rnd[3:2]);
                  ad_sh_q    <= share_enc(ad_ext[k-1], rnd[5:4]);
                  pt_sh_q    <= share_enc(pt_ext[k-1], rnd[7:6]);
               end
            end
            SHIFT: begin
               if (cnt_q == CW'(k - 1)) begin
                  state_q    <= START;
                  scnt_q     <= '0;
                  start_q    <= 1'b1;
                  key_sh_q   <= '0;
                  nonce_sh_q <= '0;
                  ad_sh_q    <= '0;
                  pt_sh_q    <= '0;
               end else begin
                  cnt_q      <= cnt_q + 1'b1;
                  key_q      <= key_q << 1;
                  nonce_q    <= nonce_q << 1;
                  ad_q       <= ad_q << 1;
                  pt_q       <= pt_q << 1;
                  key_sh_q   <= share_enc(key_q[k-1], rnd[1:0]);
                  nonce_sh_q <= share_enc(nonce_q[NONCE_W-1], rnd[3:2]);
                  ad_sh_q    <= share_enc(ad_q[k-1], rnd[5:4]);
                  pt_sh_q    <= share_enc(pt_q[k-1], rnd[7:6]);
               end
            end
            START: begin
               if (scnt_q == SW'(START_CYCLES - 1)) begin
                  state_q <= WAIT;
                  start_q <= 1'b0;
               end else begin
                  scnt_q <= scnt_q + 1'b1;
               end
            end
            WAIT: begin
               if (enc_ready_in) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ld.load_ready         = ready_q;
   assign keyxSI                = key_sh_q;
   assign noncexSI              = nonce_sh_q;
   assign associated_dataxSI    = ad_sh_q;
   assign plain_textxSI         = pt_sh_q;
   assign rxSI                  = rx_q;
   assign encryption_startxSI   = start_q;
   assign busy                  = busy_q;
   assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_ascon_share_loader.sv
// Randomized bench for ascon_share_loader: job-age model plus expected-bit queue.
module tb_ascon_share_loader;
   import ascon_pkg::*;

   localparam int K  = 128;
   localparam int L  = 40;
   localparam int Y  = 40;
   localparam int RW = 7;

   localparam logic [127:0] KEY   = 128'h7540e9d968c534f3347c799342ed1264;
   localparam logic [127:0] NONCE = 128'h3f0a465dfb478805be644a2627f7c7e8;
   localparam logic [39:0]  AD    = 40'h4153434f4e;
   localparam logic [39:0]  PT    = 40'h6173636f6e;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ascon_share_loader_if #(.K(K), .L(L), .Y(Y)) ld ();
   logic            enc_ready_in;
   logic [RW+7:0]   rand_in;
   logic [2:0]      keyxSI, noncexSI, associated_dataxSI, plain_textxSI;
   logic [RW-1:0]   rxSI;
   logic            encryption_startxSI, busy;
   state_t          dbg_state;

   ascon_share_loader dut (
      .clk                 (clk),
      .rst                 (rst),
      .ld                  (ld),
      .enc_ready_in        (enc_ready_in),
`ifndef ASCON_LOADER_LFSR_EN
      .rand_in             (rand_in),
`endif
      .keyxSI              (keyxSI),
      .noncexSI            (noncexSI),
      .associated_dataxSI  (associated_dataxSI),
      .plain_textxSI       (plain_textxSI),
      .rxSI                (rxSI),
      .encryption_startxSI (encryption_startxSI),
      .busy                (busy),
      .dbg_state_o         (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // m_age: 0 = idle, 1..128 shifting bit m_age-1, 129..131 start strobe, >=132 waiting.
   logic [3:0]     exp_q[$];
   int             m_age = 0;
   logic [RW+7:0]  prev_rand;
   bit             prev_valid = 0;
   int             rand_mode = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age      = 0;
         prev_valid = 0;
         exp_q.delete();
      end else begin
         prev_rand  = rand_in;
         prev_valid = 1;
         if (m_age == 0) begin
            if (ld.load_valid) begin
               for (int i = 0; i < K; i++) begin
                  exp_q.push_back({ld.key_in[K-1-i], ld.nonce_in[127-i],
                                   (i < L) ? ld.ad_in[L-1-i] : 1'b0,
                                   (i < Y) ? ld.pt_in[Y-1-i] : 1'b0});
               end
               m_age = 1;
            end
         end else if (m_age >= 132) begin
            if (enc_ready_in) m_age = 0;
         end else begin
            m_age++;
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [127:0] acc_key, acc_nonce, acc_ad, acc_pt;
   int           start_run, first_start_age;

   always @(negedge clk) begin
      logic [3:0] e;
      if (rst) begin
         check("rst_ready", ld.load_ready, 1);
         check("rst_busy", busy, 0);
         check("rst_start", encryption_startxSI, 0);
         check("rst_shares", {keyxSI, noncexSI, associated_dataxSI, plain_textxSI}, 0);
         check("rst_rx", rxSI, 0);
      end else begin
`ifndef ASCON_LOADER_LFSR_EN
         if (prev_valid) check("rxSI", rxSI, prev_rand[RW+7:8]);
`endif
         check("load_ready", ld.load_ready, (m_age == 0));
         check("busy", busy, (m_age != 0));
         check("start", encryption_startxSI, (m_age >= 129 && m_age <= 131));
         if (encryption_startxSI) begin
            if (start_run == 0) first_start_age = m_age;
            start_run++;
         end
         if (m_age >= 1 && m_age <= 128) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL exp_q_empty got=0 exp=1 @%0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("key_bit", ^keyxSI, e[3]);
               check("nonce_bit", ^noncexSI, e[2]);
               check("ad_bit", ^associated_dataxSI, e[1]);
               check("pt_bit", ^plain_textxSI, e[0]);
            end
            acc_key   = {acc_key[126:0], ^keyxSI};
            acc_nonce = {acc_nonce[126:0], ^noncexSI};
            acc_ad    = {acc_ad[126:0], ^associated_dataxSI};
            acc_pt    = {acc_pt[126:0], ^plain_textxSI};
`ifndef ASCON_LOADER_LFSR_EN
            if (prev_rand[7:0] == 8'h00)
               check("masks_zero", {keyxSI[2:1], noncexSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1]}, 8'h00);
            if (prev_rand[7:0] == 8'hFF)
               check("masks_ones", {keyxSI[2:1], noncexSI[2:1], associated_dataxSI[2:1], plain_textxSI[2:1]}, 8'hFF);
`endif
         end
         if (m_age >= 129 && m_age <= 131)
            check("start_shares_zero", {keyxSI, noncexSI, associated_dataxSI, plain_textxSI}, 0);
      end
   end

   // ---------------- drivers ----------------
   initial begin
      rand_in = '0;
      forever begin
         @(negedge clk);
         case (rand_mode)
            1:       rand_in = '0;
            2:       rand_in = '1;
            default: rand_in = (RW + 8)'($urandom);
         endcase
      end
   end

   task automatic run_job(input logic [127:0] kk, input logic [127:0] nn,
                          input logic [39:0] aa, input logic [39:0] pp,
                          input bit intrude, input int wait_extra);
      int g;
      acc_key = '0; acc_nonce = '0; acc_ad = '0; acc_pt = '0;
      start_run = 0; first_start_age = 0;
      @(negedge clk);
      ld.load_valid = 1'b1;
      ld.key_in = kk; ld.nonce_in = nn; ld.ad_in = aa; ld.pt_in = pp;
      @(negedge clk);
      ld.load_valid = 1'b0;
      g = 0;
      while (m_age != 0 && m_age < 132 && g < 300) begin
         enc_ready_in = 1'($urandom_range(0, 1));
         if (intrude && m_age >= 10 && m_age < 15) begin
            ld.load_valid = 1'b1;
            ld.key_in     = ~kk;
         end else begin
            ld.load_valid = 1'b0;
         end
         @(negedge clk);
         g++;
      end
      ld.load_valid = 1'b0;
      enc_ready_in  = 1'b0;
      total++;
      if (g >= 300) begin
         bad++;
         $display("FAIL job_timeout got=%0d exp=<300", g);
      end
      repeat (wait_extra) @(negedge clk);
      check("ready_low_in_wait", ld.load_ready, 0);
      enc_ready_in = 1'b1;
      @(negedge clk);
      enc_ready_in = 1'b0;
      check("ready_back", ld.load_ready, 1);
      check("busy_back", busy, 0);
   endtask

   task automatic check_pinned_job();
      check("lit_key", acc_key, KEY);
      check("lit_nonce", acc_nonce, NONCE);
      check("lit_ad", acc_ad, {AD, 88'h0});
      check("lit_pt", acc_pt, {PT, 88'h0});
      check("lit_start_first", first_start_age, 129);
      check("lit_start_len", start_run, 3);
   endtask

   // ---------------- sequence ----------------
   initial begin
      int g;
      rst = 1'b1;
      enc_ready_in = 1'b0;
      ld.load_valid = 1'b0;
      ld.key_in = '0; ld.nonce_in = '0; ld.ad_in = '0; ld.pt_in = '0;
      acc_key = '0; acc_nonce = '0; acc_ad = '0; acc_pt = '0;
      start_run = 0; first_start_age = 0;
      repeat (2) @(negedge clk);
      check("lit_rst_state", dbg_state, IDLE);
      check("lit_rst_ready", ld.load_ready, 1);
      rst = 1'b0;

`ifdef ASCON_LOADER_LFSR_EN
      begin
         logic [RW-1:0] first_rx;
         int same;
         same = 0;
         @(negedge clk);
         first_rx = rxSI;
         repeat (15) begin
            @(negedge clk);
            if (rxSI == first_rx) same++;
         end
         total++;
         if (same == 15) begin
            bad++;
            $display("FAIL rx_stuck got=%0d exp=<15", same);
         end
      end
`endif

      // directed job with intruding load during SHIFT and enc_ready noise
      run_job(KEY, NONCE, AD, PT, 1'b1, 4);
      check_pinned_job();

`ifndef ASCON_LOADER_LFSR_EN
      rand_mode = 1;
      run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {8'($urandom), $urandom}, {8'($urandom), $urandom}, 1'b0, 1);
      rand_mode = 2;
      run_job(KEY, NONCE, AD, PT, 1'b0, 2);
      check_pinned_job();
      rand_mode = 0;
`endif

      // reset in the middle of SHIFT
      start_run = 0;
      @(negedge clk);
      ld.load_valid = 1'b1;
      ld.key_in = ~KEY; ld.nonce_in = ~NONCE; ld.ad_in = ~AD; ld.pt_in = ~PT;
      @(negedge clk);
      ld.load_valid = 1'b0;
      g = 0;
      while (m_age < 60 && g < 200) begin
         @(negedge clk);
         g++;
      end
      #2 rst = 1'b1;
      #1;
      check("lit_abort_shares", {keyxSI, noncexSI, associated_dataxSI, plain_textxSI}, 0);
      check("lit_abort_start", encryption_startxSI, 0);
      check("lit_abort_busy", busy, 0);
      check("lit_abort_rx", rxSI, 0);
      check("lit_abort_ready", ld.load_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      check("lit_no_start_after_abort", start_run, 0);
      run_job(KEY, NONCE, AD, PT, 1'b0, 0);
      check_pinned_job();

      // random jobs
      for (int j = 0; j < 4; j++) begin
         run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 {8'($urandom), $urandom}, {8'($urandom), $urandom},
                 1'($urandom_range(0, 1)), $urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ascon_share_loader.md
Name: ascon_share_loader

Overview:
- Upstream feeder for the serial Ascon core.
- Accepts parallel key, nonce, associated data and plaintext through a valid/ready handshake.
- Splits every bit into 3 Boolean shares and shifts all operands MSB-first into the core's 3-bit share inputs over k cycles.
- Supplies fresh randomness on rxSI every cycle, pulses encryption_startxSI, then waits for the core's encryption_readyxSO before accepting the next job.

Parameters:
- k, 128: key size and shift length; the only legal value is 128.
- l, 40: associated-data length in bits; 1 ≤ l ≤ k.
- y, 40: plaintext length in bits; 1 ≤ y ≤ k.
- RW, 7: width of the rxSI randomness bus.
- START_CYCLES, 3: number of cycles encryption_startxSI is held high.
- LFSR_SEED, 32'hACE1_5EED: nonzero reset seed of the internal PRNG.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: asynchronous, active-high reset.
- load_valid, in, 1: a job is presented on the data inputs.
- load_ready, out, 1: the loader can accept a job.
- key_in, in, k: key.
- nonce_in, in, 128: nonce.
- ad_in, in, l: associated data.
- pt_in, in, y: plaintext.
- enc_ready_in, in, 1: driven by the core's encryption_readyxSO.
- keyxSI, out, 3: key shares.
- noncexSI, out, 3: nonce shares.
- associated_dataxSI, out, 3: AD shares.
- plain_textxSI, out, 3: PT shares.
- rxSI, out, RW: fresh randomness to the core.
- encryption_startxSI, out, 1: start strobe to the core.
- busy, out, 1: high in any state other than IDLE.
- rand_in, in, RW+8: external randomness; present only when ASCON_LOADER_LFSR_EN is undefined.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE and the bit counter clears.
  - All share outputs, rxSI and encryption_startxSI go to 0; busy goes to 0.
  - load_ready goes to 1; the PRNG loads LFSR_SEED.
- Handshake:
  - Transfer happens when load_valid && load_ready at a posedge.
  - Inputs are captured into internal shift registers in that same cycle.
  - load_ready = (state == IDLE). load_valid in any other state is ignored and no data is captured.
- States: IDLE → SHIFT → START → WAIT → IDLE.
- SHIFT:
  - Lasts exactly k cycles, with counter i running 0..k-1. The first share bits appear on the outputs in the cycle after the transfer.
  - Bit source per operand per cycle:
    - key: key[k-1-i].
    - nonce: nonce[127-i].
    - ad: ad[l-1-i] when i < l, else 0.
    - pt: pt[y-1-i] when i < y, else 0.
  - Share encoding per operand: bits [2:1] are fresh random each cycle; bit [0] = bit ^ s[1] ^ s[2]. This uses 8 random bits per cycle.
  - When i == k-1, go to START.
- START:
  - encryption_startxSI = 1 for exactly START_CYCLES cycles.
  - Share outputs are held at 0.
  - Then go to WAIT.
- WAIT:
  - Stay until enc_ready_in == 1, then go to IDLE.
  - enc_ready_in sampled high in IDLE, SHIFT or START has no effect.
- rxSI:
  - Driven with fresh random bits every cycle in every state except reset.
  - The core consumes it continuously during the permutation.
- Counter:
  - Width $clog2(k+1).
  - Saturates; it never wraps inside a job and clears on entry to SHIFT.
- Reset mid-operation: abort immediately. No start pulse is emitted and the partially shifted job is discarded.

Optional Feature:
- Macro: ASCON_LOADER_LFSR_EN.
- Defined:
  - Internal 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded with LFSR_SEED.
  - The LFSR advances RW+8 steps' worth per cycle via an unrolled update.
  - The rand_in port is absent.
- Undefined:
  - rand_in supplies all RW+8 random bits each cycle: bits [RW+7:8] drive rxSI and bits [7:0] drive the share masks.
  - No internal PRNG.

Decomposition:
- Package ascon_pkg holds:
  - the state enum (IDLE/SHIFT/START/WAIT);
  - constants NONCE_W = 128 and SHARES = 3;
  - the LFSR polynomial and tap constant.
- One sub-module, ascon_lfsr, instantiated under ASCON_LOADER_LFSR_EN.

Test Plan:
1. Load KEY=7540e9d968c534f3347c799342ed1264, NONCE=3f0a465dfb478805be644a2627f7c7e8, AD=4153434f4e, PT=6173636f6e → the XOR of the 3 shares, reassembled over 128 cycles, equals KEY and NONCE exactly; AD and PT reassemble to the given values in the first 40 bits and 0 for the remaining 88 cycles.
2. Same job → encryption_startxSI is high for exactly 3 cycles starting at cycle 129 after the transfer; load_ready stays 0 until enc_ready_in is pulsed, then returns to 1 the next cycle.
3. Assert load_valid with a different key during SHIFT → not captured; the shifted key still equals the first key.
4. Assert rst at shift cycle 60 → all outputs are 0 asynchronously; no start pulse; a new job loaded afterwards shifts correctly from bit 127.
5. With ASCON_LOADER_LFSR_EN undefined, rand_in = 0 every cycle → share[0] equals the raw bit and share[2:1] = 0; with rand_in = all-ones → share[0] = the raw bit, since the two mask bits cancel.
6. With the LFSR enabled → rxSI is never stuck: no repeated identical RW-bit value across 16 consecutive cycles after reset with the default seed.
